// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
//
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment
// display. A multi-digit hex value is held in an active buffer and presented
// one digit per slot. Each slot drives the digit nibble to an external
// hex-to-7-segment decoder and drives the matching active-low anode and
// decimal point.
//
// Features:
//   - Double buffering. New values land in a pending buffer and are copied to
//     the active buffer only at the frame boundary, so a frame never tears.
//   - Anti-ghosting guard. All anodes are off for the first GUARD cycles of
//     every slot, which gives the segment lines time to settle.
//   - Optional leading-zero blanking.
//
// Parameters:
//   NUM_DIGITS  number of display digits (2..8)
//   REFRESH_DIV clock cycles per digit slot (>= GUARD+2)
//   GUARD       cycles at the start of each slot with all anodes off
//   LZB         1 enables leading-zero blanking, 0 disables it
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active high
//   value        in   display value; digit 0 is bits [3:0] (rightmost)
//   dp_in        in   decimal point per digit, 1 = lit
//   load         in   1-cycle strobe; captures value/dp_in into pending buffer
//   en           in   display enable (registered, takes effect one cycle later)
//   digit_hex    out  nibble of the current digit, to the decoder
//   an           out  anode selects, active low, one-hot-low when lit
//   dp           out  decimal point, active low
//   frame_start  out  1-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned LZB         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    en,
  output logic [3:0]              digit_hex,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic                    r_en_q;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_active_val;
  logic [NUM_DIGITS-1:0]   r_active_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;

  // Registered outputs
  logic [3:0]              r_digit_hex;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;
  logic                    r_frame_start;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_commit;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_active_val_nxt;
  logic [NUM_DIGITS-1:0]   w_active_dp_nxt;

  // Output-path signals
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_blank_sel;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic                    w_dp_nxt;

  // ---------------------------------------------------------------------------
  // Prescaler, digit index and frame-boundary commit
  // ---------------------------------------------------------------------------
  always_comb begin
    // The prescaler is frozen while disabled, so a tick can only be seen with
    // the display running; this also suppresses commits while disabled.
    w_tick   = r_en_q && (r_cnt == CNT_LAST);
    w_wrap   = w_tick && (r_idx == IDX_LAST);
    w_commit = w_wrap && r_pend_valid;

    w_cnt_nxt = r_cnt;
    if (r_en_q) begin
      w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end

    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end

    w_active_val_nxt = r_active_val;
    w_active_dp_nxt  = r_active_dp;
    if (w_commit) begin
      w_active_val_nxt = r_pend_val;
      w_active_dp_nxt  = r_pend_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_q       <= 1'b0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_en_q       <= en;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_active_val <= w_active_val_nxt;
      r_active_dp  <= w_active_dp_nxt;
      // A load on the commit edge wins over the clear: the old pending data
      // moves to active above while the new data stays pending.
      if (load) begin
        r_pend_val   <= value;
        r_pend_dp    <= dp_in;
        r_pend_valid <= 1'b1;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking, evaluated on the value that will be active after
  // this edge. Walks from the most significant digit down; digit 0 is never
  // blanked so an all-zero value still shows a single "0".
  // ---------------------------------------------------------------------------
  always_comb begin
    logic        w_zero_run;
    int unsigned d;
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      d          = NUM_DIGITS - k;
      w_zero_run = w_zero_run && (w_active_val_nxt[4*d +: 4] == 4'h0);
      w_blank[d] = (LZB != 0) && w_zero_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are computed from the next-state cnt/idx/active so
  // the registered outputs line up with the new index on the same edge. The
  // enable term uses the current en_q, which is why a change on en shows on
  // the anodes two edges after the input moves.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nib       = 4'h0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib       = w_active_val_nxt[4*i +: 4];
        w_dp_sel    = w_active_dp_nxt[i];
        w_blank_sel = w_blank[i];
      end
    end

    w_lit = r_en_q && (w_cnt_nxt >= CNT_GUARD) && !w_blank_sel;

    w_an_nxt = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_an_nxt[i] = !(w_lit && (w_idx_nxt == IDX_W'(i)));
    end

    w_dp_nxt = !(w_lit && w_dp_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit_hex   <= 4'h0;
      r_an          <= '1;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_digit_hex   <= w_nib;
      r_an          <= w_an_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= w_wrap;
    end
  end

  assign digit_hex   = r_digit_hex;
  assign an          = r_an;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
//
// Directed bench for seg_scan_mux with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
// A frame is 32 cycles; cycle c of a frame is slot c/8, prescaler count c%8,
// with cycle 0 being the sample where frame_start is high.
// Observed word per cycle: {digit_hex, an, dp, frame_start}.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        en;
  logic [3:0]  digit_hex;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(8),
    .GUARD      (2),
    .LZB        (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .en         (en),
    .digit_hex  (digit_hex),
    .an         (an),
    .dp         (dp),
    .frame_start(frame_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {digit_hex, an, dp, frame_start};
  endfunction

  // Expected word for cycle c of a frame showing nib, with per-slot lit mask
  // (leading-zero blanking worked out by hand) and dp mask. on=0 models the
  // display being dark while disabled.
  function automatic logic [9:0] exp_word(input logic [15:0] nib,
                                          input logic [3:0] lit,
                                          input logic [3:0] dpm,
                                          input int c, input logic on);
    int          s;
    int          k;
    logic [15:0] sh;
    logic [3:0]  a;
    logic        d;
    s  = c / 8;
    k  = c % 8;
    sh = nib >> (4 * s);
    a  = 4'hF;
    d  = 1'b1;
    if (on && k >= 2 && lit[s]) begin
      a[s] = 1'b0;
      d    = ~dpm[s];
    end
    return {sh[3:0], a, d, (c == 0)};
  endfunction

  // Walks one full frame from its cycle-0 sample, checking every cycle, and
  // optionally strobes load at cycles la / lb. Ends on the next frame's
  // cycle-0 sample.
  task automatic scan_frame(input string name, input logic [15:0] nib,
                            input logic [3:0] lit, input logic [3:0] dpm,
                            input int la, input logic [15:0] va,
                            input int lb, input logic [15:0] vb);
    logic [9:0] e;
    logic [9:0] o;
    for (int c = 0; c < 32; c++) begin
      e = exp_word(nib, lit, dpm, c, 1'b1);
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s c=%0d: got hex=%h an=%b dp=%b fs=%b, want hex=%h an=%b dp=%b fs=%b",
                 name, c, o[9:6], o[5:2], o[1], o[0], e[9:6], e[5:2], e[1], e[0]);
      end
      load = 1'b0;
      if (c == la) begin
        load = 1'b1; value = va; dp_in = 4'h0;
      end else if (c == lb) begin
        load = 1'b1; value = vb; dp_in = 4'h0;
      end
      step();
    end
    load = 1'b0;
  endtask

  // Steps until frame_start is seen, bounded; lands on a cycle-0 sample.
  task automatic wait_frame(input string name);
    int n;
    n = 0;
    step();
    while (frame_start !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start wait: got fs=%b after %0d cycles, want 1", name, frame_start, n);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load  = 1'b1;
    value = v;
    dp_in = d;
    step();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
    step();
    step();
    checks++;
    if (obs() !== {4'h0, 4'hF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: got hex=%h an=%b dp=%b fs=%b, want hex=0 an=1111 dp=1 fs=0",
               digit_hex, an, dp, frame_start);
    end
  endtask

  task automatic test_basic_scan();
    rst = 1'b0; en = 1'b1;
    do_load(16'h12AB, 4'b0000);
    wait_frame("basic");
    scan_frame("basic_f1", 16'h12AB, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0);
    scan_frame("basic_f2", 16'h12AB, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_lzb();
    do_load(16'h0005, 4'b0000);
    wait_frame("lzb_0005");
    scan_frame("lzb_0005", 16'h0005, 4'b0001, 4'b0000, -1, 16'h0, -1, 16'h0);
    do_load(16'h0105, 4'b0000);
    wait_frame("lzb_0105");
    scan_frame("lzb_0105", 16'h0105, 4'b0111, 4'b0000, -1, 16'h0, -1, 16'h0);
    // Blanked digit 1 has its dp bit set and must stay dark.
    do_load(16'h0000, 4'b0010);
    wait_frame("lzb_0000");
    scan_frame("lzb_0000", 16'h0000, 4'b0001, 4'b0010, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_mid_frame_update();
    scan_frame("mid_old", 16'h0000, 4'b0001, 4'b0010, 10, 16'h1111, 12, 16'h2222);
    scan_frame("mid_new", 16'h2222, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_back_to_back();
    scan_frame("b2b_2222", 16'h2222, 4'b1111, 4'b0000, 5, 16'h4444, 31, 16'h3333);
    scan_frame("b2b_4444", 16'h4444, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0);
    scan_frame("b2b_3333", 16'h3333, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0);
  endtask

  task automatic test_dp();
    do_load(16'h1234, 4'b0100);
    wait_frame("dp");
    scan_frame("dp_1234", 16'h1234, 4'b1111, 4'b0100, -1, 16'h0, -1, 16'h0);
  endtask

  // en drops while cnt=4 of slot 2; the scan freezes at idx=2, cnt=5.
  task automatic test_enable();
    logic [9:0] e;
    logic [9:0] o;
    for (int c = 0; c <= 20; c++) begin
      e = exp_word(16'h1234, 4'b1111, 4'b0100, c, 1'b1);
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_pre c=%0d: got %b want %b", c, o, e);
      end
      if (c == 20) en = 1'b0;
      step();
    end
    e = exp_word(16'h1234, 4'b1111, 4'b0100, 21, 1'b1);
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL en_lag: got %b want %b", o, e);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      e = exp_word(16'h1234, 4'b1111, 4'b0100, 21, 1'b0);
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_dark k=%0d: got %b want %b", k, o, e);
      end
    end
    en = 1'b1;
    step();
    e = exp_word(16'h1234, 4'b1111, 4'b0100, 21, 1'b0);
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL en_relag: got %b want %b", o, e);
    end
    step();
    for (int c = 22; c < 32; c++) begin
      e = exp_word(16'h1234, 4'b1111, 4'b0100, c, 1'b1);
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_resume c=%0d: got %b want %b", c, o, e);
      end
      step();
    end
    e = exp_word(16'h1234, 4'b1111, 4'b0100, 0, 1'b1);
    o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL en_wrap: got %b want %b", o, e);
    end
  endtask

  // Load 5678 early in the frame, then reset at idx=3 with it still pending.
  task automatic test_reset_mid();
    logic [9:0] e;
    logic [9:0] o;
    for (int c = 0; c <= 26; c++) begin
      e = exp_word(16'h1234, 4'b1111, 4'b0100, c, 1'b1);
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rstmid_pre c=%0d: got %b want %b", c, o, e);
      end
      load = (c == 2);
      value = 16'h5678;
      dp_in = 4'hF;
      if (c == 26) rst = 1'b1;
      step();
    end
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs() !== {4'h0, 4'hF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL rstmid_reset k=%0d: got hex=%h an=%b dp=%b fs=%b, want hex=0 an=1111 dp=1 fs=0",
                 k, digit_hex, an, dp, frame_start);
      end
      if (k == 0) step();
    end
    rst = 1'b0;
    wait_frame("rstmid");
    scan_frame("rstmid_after", 16'h0000, 4'b0001, 4'b0000, -1, 16'h0, -1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_lzb();
    test_mid_frame_update();
    test_back_to_back();
    test_dp();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
